// File: rtl/nco_gen_pkg.sv
// rtl/nco_gen_pkg.sv - shared state encoding and default widths for the NCO generator
package nco_gen_pkg;

  localparam int NCO_PHASE_W_DEF = 16;
  localparam int NCO_CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } nco_state_e;

endpackage

// File: rtl/nco_gen_if.sv
// rtl/nco_gen_if.sv - control, tuning-word handshake and status bundle of the NCO generator
interface nco_gen_if #(
  parameter int PHASE_W = 16,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               stop;
  logic [PHASE_W-1:0] fcw;
  logic               fcw_valid;
  logic               fcw_ready;
  logic [PHASE_W-1:0] phase_step;
  logic               step_valid;
  logic [CNT_W-1:0]   burst_len;
  logic               out;
  logic [PHASE_W-1:0] phase;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   period_cnt;

  modport master (
    output start, stop, fcw, fcw_valid, phase_step, step_valid, burst_len,
    input  fcw_ready, out, phase, busy, done, period_cnt
  );

  modport slave (
    input  start, stop, fcw, fcw_valid, phase_step, step_valid, burst_len,
    output fcw_ready, out, phase, busy, done, period_cnt
  );
endinterface

// File: rtl/nco_phase_acc.sv
// rtl/nco_phase_acc.sv - phase accumulator register with wrap (carry-out) detection
module nco_phase_acc #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [PHASE_W-1:0] fcw_i,
  input  logic [PHASE_W-1:0] step_i,
  input  logic               step_en_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               wrap_o
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W+1:0] sum;

  // Two guard bits: phase + fcw + step can carry twice, which still counts as a single wrap.
  always_comb begin
    sum     = {2'b00, phase_q} + {2'b00, fcw_i} + (step_en_i ? {2'b00, step_i} : '0);
    wrap_o  = |sum[PHASE_W+1:PHASE_W];
    phase_d = phase_q;
    if (clear_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = sum[PHASE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/nco_gen.sv
// rtl/nco_gen.sv - NCO square-wave generator: run/stop FSM, tuning-word handshake, period counting
module nco_gen
  import nco_gen_pkg::*;
#(
  parameter int PHASE_W = NCO_PHASE_W_DEF,
  parameter int CNT_W   = NCO_CNT_W_DEF
) (
  input logic      clk,
  input logic      rst,
  nco_gen_if.slave bus
);

  nco_state_e         state_q, state_d;
  logic [PHASE_W-1:0] fcw_act_q, fcw_act_d;
  logic [PHASE_W-1:0] pend_fcw_q, pend_fcw_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  logic               busy;
  logic               acc_clear;
  logic               acc_wrap;
  logic               wrap_ev;
  logic               finish;
  logic [CNT_W-1:0]   cnt_inc;
  logic [PHASE_W-1:0] phase;

  assign busy = (state_q != ST_IDLE);

  nco_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (acc_clear),
    .en_i     (busy),
    .fcw_i    (fcw_act_q),
    .step_i   (bus.phase_step),
    .step_en_i(bus.step_valid),
    .phase_o  (phase),
    .wrap_o   (acc_wrap)
  );

  always_comb begin
    state_d    = state_q;
    fcw_act_d  = fcw_act_q;
    pend_fcw_d = pend_fcw_q;
    pend_d     = pend_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    acc_clear  = 1'b0;
    finish     = 1'b0;
    wrap_ev    = busy && acc_wrap;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        acc_clear = 1'b1;
        if (bus.start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          burst_d = bus.burst_len;
        end
      end
      ST_RUN: begin
        if (wrap_ev) cnt_d = cnt_inc;
        // A burst-ending wrap wins over a simultaneous stop so done fires only once.
        if (wrap_ev && (burst_q != '0) && (cnt_inc == burst_q)) begin
          finish = 1'b1;
        end else if (bus.stop) begin
          if (fcw_act_q == '0) finish = 1'b1;
          else                 state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (wrap_ev) cnt_d = cnt_inc;
        if (wrap_ev || (fcw_act_q == '0)) finish = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d   = ST_IDLE;
      done_d    = 1'b1;
      acc_clear = 1'b1;
    end

    // Pending word lands immediately when idle, otherwise only at a wrap to keep periods whole.
    if (pend_q && ((state_q == ST_IDLE) || wrap_ev)) begin
      fcw_act_d = pend_fcw_q;
      pend_d    = 1'b0;
    end else if (bus.fcw_valid && !pend_q) begin
      pend_fcw_d = bus.fcw;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fcw_act_q  <= '0;
      pend_fcw_q <= '0;
      pend_q     <= 1'b0;
      burst_q    <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcw_act_q  <= fcw_act_d;
      pend_fcw_q <= pend_fcw_d;
      pend_q     <= pend_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign bus.phase      = phase;
  assign bus.out        = phase[PHASE_W-1];
  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.period_cnt = cnt_q;
  assign bus.fcw_ready  = ~pend_q;

endmodule

// File: tb/tb_nco_gen.sv
// tb/tb_nco_gen.sv - directed bench for nco_gen with a cycle-level arithmetic reference model
module tb_nco_gen;

  localparam int PW   = 16;
  localparam int CW   = 16;
  localparam int PMOD = 1 << PW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nco_gen_if #(.PHASE_W(PW), .CNT_W(CW)) bus ();

  nco_gen #(.PHASE_W(PW), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 running, 2 stopping.
  int m_mode = 0;
  int m_phase = 0;
  int m_fcw = 0;
  int m_pend = 0;
  int m_pend_fcw = 0;
  int m_cnt = 0;
  int m_burst = 0;
  int m_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] lit);
    chk(name, dut_v, lit);
    chk({name, "_model"}, mdl_v, lit);
  endtask

  task automatic model_step();
    int total;
    int old_mode;
    bit wrap;
    bit fin;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_fcw = 0; m_pend = 0; m_cnt = 0; m_done = 0;
      return;
    end
    old_mode = m_mode;
    m_done = 0;
    wrap = 0;
    fin = 0;
    if (old_mode == 0) begin
      m_phase = 0;
      if (bus.start) begin
        m_mode = 1; m_cnt = 0; m_burst = int'(bus.burst_len);
      end
    end else begin
      total = m_phase + m_fcw + (bus.step_valid ? int'(bus.phase_step) : 0);
      wrap = (total >= PMOD);
      m_phase = total % PMOD;
      if (wrap && m_cnt < CMAX) m_cnt++;
      if (wrap && old_mode == 2) fin = 1;
      if (wrap && m_burst != 0 && m_cnt == m_burst) fin = 1;
      if (old_mode == 1 && bus.stop && !fin) begin
        if (m_fcw == 0) fin = 1;
        else m_mode = 2;
      end
      if (old_mode == 2 && m_fcw == 0) fin = 1;
      if (fin) begin
        m_mode = 0; m_phase = 0; m_done = 1;
      end
    end
    if (m_pend != 0 && (old_mode == 0 || wrap)) begin
      m_fcw = m_pend_fcw; m_pend = 0;
    end else if (bus.fcw_valid && m_pend == 0) begin
      m_pend = 1; m_pend_fcw = int'(bus.fcw);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("phase",      32'(bus.phase),      32'(m_phase));
    chk("out",        32'(bus.out),        32'((m_phase >> (PW - 1)) & 1));
    chk("busy",       32'(bus.busy),       32'(m_mode != 0));
    chk("done",       32'(bus.done),       32'(m_done));
    chk("period_cnt", 32'(bus.period_cnt), 32'(m_cnt));
    chk("fcw_ready",  32'(bus.fcw_ready),  32'(m_pend == 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_fcw(input logic [PW-1:0] w);
    bus.fcw = w; bus.fcw_valid = 1'b1;
    cycle();
    bus.fcw_valid = 1'b0;
  endtask

  task automatic start_run(input logic [CW-1:0] blen);
    bus.burst_len = blen; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.fcw = '0; bus.fcw_valid = 0;
    bus.phase_step = '0; bus.step_valid = 0; bus.burst_len = '0;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    pin("rst_phase", 32'(bus.phase), 32'(m_phase), 32'h0);
    pin("rst_busy",  32'(bus.busy),  32'(m_mode != 0), 32'h0);
    pin("rst_ready", 32'(bus.fcw_ready), 32'(m_pend == 0), 32'h1);
    pin("rst_cnt",   32'(bus.period_cnt), 32'(m_cnt), 32'h0);

    // Free-running 16-cycle period.
    load_fcw(16'h1000);
    pin("idle_accept_ready", 32'(bus.fcw_ready), 32'(m_pend == 0), 32'h0);
    cycle();
    pin("idle_apply_ready", 32'(bus.fcw_ready), 32'(m_pend == 0), 32'h1);
    start_run('0);
    pin("start_busy", 32'(bus.busy), 32'(m_mode != 0), 32'h1);
    run(7);
    pin("k7_out", 32'(bus.out), 32'((m_phase >> 15) & 1), 32'h0);
    run(1);
    pin("k8_out", 32'(bus.out), 32'((m_phase >> 15) & 1), 32'h1);
    run(7);
    pin("k15_phase", 32'(bus.phase), 32'(m_phase), 32'hF000);
    run(1);
    pin("k16_phase", 32'(bus.phase), 32'(m_phase), 32'h0);
    pin("k16_cnt", 32'(bus.period_cnt), 32'(m_cnt), 32'h1);

    // Retune mid-period: takes effect only after the wrap.
    run(3);
    pin("k19_phase", 32'(bus.phase), 32'(m_phase), 32'h3000);
    load_fcw(16'h2000);
    pin("k20_ready", 32'(bus.fcw_ready), 32'(m_pend == 0), 32'h0);
    pin("k20_phase", 32'(bus.phase), 32'(m_phase), 32'h4000);
    run(11);
    pin("k31_ready", 32'(bus.fcw_ready), 32'(m_pend == 0), 32'h0);
    run(1);
    pin("k32_ready", 32'(bus.fcw_ready), 32'(m_pend == 0), 32'h1);
    pin("k32_cnt", 32'(bus.period_cnt), 32'(m_cnt), 32'h2);
    run(4);
    pin("k36_phase", 32'(bus.phase), 32'(m_phase), 32'h8000);
    run(4);
    pin("k40_cnt", 32'(bus.period_cnt), 32'(m_cnt), 32'h3);

    // Graceful stop at phase 0x4000.
    run(2);
    pin("k42_phase", 32'(bus.phase), 32'(m_phase), 32'h4000);
    bus.stop = 1'b1; cycle(); bus.stop = 1'b0;
    run(4);
    pin("k47_busy", 32'(bus.busy), 32'(m_mode != 0), 32'h1);
    run(1);
    pin("stop_done", 32'(bus.done), 32'(m_done), 32'h1);
    pin("stop_busy", 32'(bus.busy), 32'(m_mode != 0), 32'h0);
    pin("stop_phase", 32'(bus.phase), 32'(m_phase), 32'h0);
    run(1);
    pin("stop_done_clr", 32'(bus.done), 32'(m_done), 32'h0);
    pin("idle_cnt_hold", 32'(bus.period_cnt), 32'(m_cnt), 32'h4);

    // Three-period burst.
    load_fcw(16'h1000);
    cycle();
    start_run(16'd3);
    run(47);
    pin("burst47_busy", 32'(bus.busy), 32'(m_mode != 0), 32'h1);
    pin("burst47_cnt", 32'(bus.period_cnt), 32'(m_cnt), 32'h2);
    run(1);
    pin("burst48_done", 32'(bus.done), 32'(m_done), 32'h1);
    pin("burst48_busy", 32'(bus.busy), 32'(m_mode != 0), 32'h0);
    pin("burst48_cnt", 32'(bus.period_cnt), 32'(m_cnt), 32'h3);
    run(2);

    // One-shot phase step, start ignored while running, then stop.
    start_run('0);
    cycle();
    pin("step_pre_phase", 32'(bus.phase), 32'(m_phase), 32'h1000);
    bus.phase_step = 16'h8000; bus.step_valid = 1'b1; bus.start = 1'b1;
    cycle();
    bus.step_valid = 1'b0; bus.start = 1'b0;
    pin("step_phase", 32'(bus.phase), 32'(m_phase), 32'hA000);
    pin("step_out", 32'(bus.out), 32'((m_phase >> 15) & 1), 32'h1);
    bus.stop = 1'b1; cycle(); bus.stop = 1'b0;
    run(8);

    // start+stop together starts; stop on the burst-ending (double-step) wrap gives one done.
    load_fcw(16'hF000);
    cycle();
    bus.stop = 1'b1;
    start_run(16'd1);
    bus.stop = 1'b0;
    pin("startstop_busy", 32'(bus.busy), 32'(m_mode != 0), 32'h1);
    bus.phase_step = 16'hF000; bus.step_valid = 1'b1; bus.stop = 1'b1;
    cycle();
    bus.step_valid = 1'b0; bus.stop = 1'b0;
    pin("coincide_done", 32'(bus.done), 32'(m_done), 32'h1);
    pin("coincide_cnt", 32'(bus.period_cnt), 32'(m_cnt), 32'h1);
    run(2);

    // Double carry counts once.
    load_fcw(16'hFFFF);
    cycle();
    start_run('0);
    cycle();
    pin("dc_pre_phase", 32'(bus.phase), 32'(m_phase), 32'hFFFF);
    bus.phase_step = 16'hFFFF; bus.step_valid = 1'b1;
    cycle();
    bus.step_valid = 1'b0;
    pin("dc_phase", 32'(bus.phase), 32'(m_phase), 32'hFFFD);
    pin("dc_cnt", 32'(bus.period_cnt), 32'(m_cnt), 32'h1);
    run(3);

    // Reset mid-run with an update pending.
    load_fcw(16'h1234);
    pin("pend_ready", 32'(bus.fcw_ready), 32'(m_pend == 0), 32'h0);
    rst = 1'b1; cycle(); rst = 1'b0;
    pin("mrst_ready", 32'(bus.fcw_ready), 32'(m_pend == 0), 32'h1);
    pin("mrst_busy", 32'(bus.busy), 32'(m_mode != 0), 32'h0);
    pin("mrst_cnt", 32'(bus.period_cnt), 32'(m_cnt), 32'h0);
    pin("mrst_phase", 32'(bus.phase), 32'(m_phase), 32'h0);

    // fcw_act is zero after reset: stop ends the run at once.
    start_run('0);
    cycle();
    pin("zero_fcw_phase", 32'(bus.phase), 32'(m_phase), 32'h0);
    bus.stop = 1'b1; cycle(); bus.stop = 1'b0;
    pin("zero_fcw_done", 32'(bus.done), 32'(m_done), 32'h1);
    pin("zero_fcw_busy", 32'(bus.busy), 32'(m_mode != 0), 32'h0);
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
